// File: rtl/seq_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_ctrl_if
// Description : Byte handshake and status bundle between a byte producer and
//               seq_scan_ctrl.
//               master : producer side. Drives in_valid, in_data, overlap and
//                        clear; observes in_ready and the status outputs.
//               slave  : controller side.
// Revision    : 1.0  initial release
// ============================================================================
interface seq_scan_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             overlap;
    logic             clear;
    logic             busy;
    logic             bit_out;
    logic             seq_seen;
    logic [CNT_W-1:0] match_count;

    modport master (
        output in_valid, in_data, overlap, clear,
        input  in_ready, busy, bit_out, seq_seen, match_count
    );

    modport slave (
        input  in_valid, in_data, overlap, clear,
        output in_ready, busy, bit_out, seq_seen, match_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_ctrl
// Description : Accepts bytes on a valid/ready handshake and serializes each
//               byte MSB first, one bit per clock, into a 4-bit pattern
//               matcher. Each match gives a one-cycle seq_seen pulse and
//               increments a saturating match counter. Overlapping or
//               non-overlapping detection is chosen per byte.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous active-high reset
//               bus (slave)  - in_valid/in_data/in_ready handshake, overlap,
//                              clear, busy, bit_out, seq_seen, match_count
// Revision    : 1.0  initial release
// ============================================================================
module seq_scan_ctrl #(
    parameter logic [3:0] PATTERN = 4'b1011,
    parameter int         CNT_W   = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    seq_scan_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    logic [7:0]       r_sreg;
    logic [2:0]       r_idx;
    logic             r_mode;
    logic [2:0]       r_hist;
    logic [2:0]       r_fill;
    logic             r_seq_seen;
    logic [CNT_W-1:0] r_match_count;

    logic             w_in_ready;
    logic             w_bit_out;
    logic             w_accept;
    logic             w_consume;
    logic             w_match;

    // Ready on the last-bit cycle as well, so back-to-back bytes have no
    // bubble. Forced low while reset is held.
    assign w_in_ready = ~reset & ((r_state == ST_IDLE) || (r_idx == 3'd0));
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_consume  = (r_state == ST_SHIFT);
    assign w_bit_out  = w_consume ? r_sreg[r_idx] : 1'b0;
    // History must hold three real bits before a match is allowed.
    assign w_match    = w_consume && (r_fill == 3'd3) &&
                        ({r_hist, w_bit_out} == PATTERN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sreg        <= 8'd0;
            r_idx         <= 3'd0;
            r_mode        <= 1'b0;
            r_hist        <= 3'd0;
            r_fill        <= 3'd0;
            r_seq_seen    <= 1'b0;
            r_match_count <= '0;
        end else begin
            // Byte scheduler
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_sreg  <= bus.in_data;
                    r_idx   <= 3'd7;
                    r_mode  <= bus.overlap;
                    r_state <= ST_SHIFT;
                end
            end else begin
                if (r_idx == 3'd0) begin
                    if (w_accept) begin
                        r_sreg  <= bus.in_data;
                        r_idx   <= 3'd7;
                        r_mode  <= bus.overlap;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end else begin
                    r_idx <= r_idx - 3'd1;
                end
            end

            // Matcher. r_mode still belongs to the byte whose bit is being
            // consumed, even on a reload edge, because the reload is
            // non-blocking.
            if (bus.clear) begin
                r_match_count <= '0;
                r_hist        <= 3'd0;
                r_fill        <= 3'd0;
                r_seq_seen    <= 1'b0;
            end else if (w_consume) begin
                r_seq_seen <= w_match;
                if (w_match) begin
                    if (r_match_count != c_cnt_max) begin
                        r_match_count <= r_match_count + 1'b1;
                    end
                    if (r_mode) begin
                        r_hist <= {r_hist[1:0], w_bit_out};
                        r_fill <= 3'd3;
                    end else begin
                        r_hist <= 3'd0;
                        r_fill <= 3'd0;
                    end
                end else begin
                    r_hist <= {r_hist[1:0], w_bit_out};
                    if (r_fill != 3'd3) begin
                        r_fill <= r_fill + 3'd1;
                    end
                end
            end else begin
                r_seq_seen <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.busy        = (r_state == ST_SHIFT);
    assign bus.bit_out     = w_bit_out;
    assign bus.seq_seen    = r_seq_seen;
    assign bus.match_count = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_scan_ctrl
// Description : Self-checking bench for seq_scan_ctrl. Expected match pulses
//               (edge number relative to the first accept, and counter value)
//               are queued before each stream and popped as pulses appear.
//               A second instance with CNT_W=2 shares the stimulus and is
//               used for the saturation scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_scan_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.CNT_W(8)) bus_a ();
    seq_scan_ctrl_if #(.CNT_W(2)) bus_b ();

    assign bus_b.in_valid = bus_a.in_valid;
    assign bus_b.in_data  = bus_a.in_data;
    assign bus_b.overlap  = bus_a.overlap;
    assign bus_b.clear    = bus_a.clear;

    seq_scan_ctrl #(.PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seq_scan_ctrl #(.PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        int         e;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push_exp(input int e, input logic [7:0] cnt);
        exp_t x;
        x.e   = e;
        x.cnt = cnt;
        sb_q.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives nbytes (1 or 2) with in_valid held until the last accept and
    // monitors every cycle for (8*nbytes + extra) edges. Edge 0 is the
    // first accept edge. clr_edge < 0 disables clear.
    task automatic run_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input int nbytes, input logic ovl,
                              input int clr_edge, input int extra,
                              input bit use_b);
        int total;
        total = 8 * nbytes + extra;
        for (int e = 0; e < total; e++) begin
            logic       seen;
            logic [7:0] cnt;
            logic [7:0] cur;
            logic       exp_busy;
            logic       exp_rdy;
            logic       exp_bit;
            bus_a.in_valid = (e <= 8 * (nbytes - 1));
            bus_a.in_data  = (e == 0) ? b0 : b1;
            bus_a.overlap  = ovl;
            bus_a.clear    = (e == clr_edge);
            @(posedge clk);
            #1;
            bus_a.in_valid = 1'b0;
            bus_a.clear    = 1'b0;

            seen = use_b ? bus_b.seq_seen : bus_a.seq_seen;
            cnt  = use_b ? {6'd0, bus_b.match_count} : bus_a.match_count;

            if (sb_q.size() > 0 && sb_q[0].e == e) begin
                checks++;
                if (seen !== 1'b1) begin
                    failures++;
                    $display("FAIL pulse_missing: edge %0d seq_seen=%b expected 1", e, seen);
                end else begin
                    checks++;
                    if (cnt !== sb_q[0].cnt) begin
                        failures++;
                        $display("FAIL pulse_count: edge %0d match_count=%0d expected %0d",
                                 e, cnt, sb_q[0].cnt);
                    end
                end
                void'(sb_q.pop_front());
            end else begin
                checks++;
                if (seen !== 1'b0) begin
                    failures++;
                    $display("FAIL pulse_unexpected: edge %0d seq_seen=%b expected 0", e, seen);
                end
            end

            exp_busy = (e < 8 * nbytes);
            checks++;
            if (bus_a.busy !== exp_busy) begin
                failures++;
                $display("FAIL busy: edge %0d busy=%b expected %b", e, bus_a.busy, exp_busy);
            end

            exp_rdy = ((e % 8) == 7) || (e >= 8 * nbytes);
            checks++;
            if (bus_a.in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL in_ready: edge %0d in_ready=%b expected %b", e, bus_a.in_ready, exp_rdy);
            end

            cur     = (e < 8) ? b0 : b1;
            exp_bit = exp_busy ? cur[7 - (e % 8)] : 1'b0;
            checks++;
            if (bus_a.bit_out !== exp_bit) begin
                failures++;
                $display("FAIL bit_out: edge %0d bit_out=%b expected %b", e, bus_a.bit_out, exp_bit);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d pulses not seen, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_count(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: match_count=%0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (bus_a.in_ready !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.bit_out !== 1'b0 ||
            bus_a.seq_seen !== 1'b0 || bus_a.match_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b busy=%b bit=%b seen=%b cnt=%0d expected 0 0 0 0 0",
                     bus_a.in_ready, bus_a.busy, bus_a.bit_out, bus_a.seq_seen, bus_a.match_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", bus_a.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_nonoverlap();
        do_reset();
        push_exp(4, 8'd1);
        run_stream(8'hB0, 8'h00, 1, 1'b0, -1, 3, 1'b0);
        check_count("nonoverlap_final", bus_a.match_count, 8'd1);
    endtask

    task automatic test_mode();
        do_reset();
        push_exp(5, 8'd1);
        push_exp(8, 8'd2);
        run_stream(8'h5B, 8'h00, 1, 1'b1, -1, 3, 1'b0);
        check_count("overlap_final", bus_a.match_count, 8'd2);
        do_reset();
        push_exp(5, 8'd1);
        run_stream(8'h5B, 8'h00, 1, 1'b0, -1, 3, 1'b0);
        check_count("nonoverlap_5b_final", bus_a.match_count, 8'd1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_exp(11, 8'd1);
        run_stream(8'h01, 8'h60, 2, 1'b1, -1, 3, 1'b0);
        check_count("cross_byte_final", bus_a.match_count, 8'd1);
    endtask

    task automatic test_saturation();
        do_reset();
        push_exp(4, 8'd1);
        push_exp(8, 8'd2);
        push_exp(12, 8'd3);
        push_exp(16, 8'd3);
        run_stream(8'hBB, 8'hBB, 2, 1'b0, -1, 3, 1'b1);
        check_count("sat_final", {6'd0, bus_b.match_count}, 8'd3);
        check_count("sat_wide_final", bus_a.match_count, 8'd4);
    endtask

    task automatic test_clear();
        do_reset();
        run_stream(8'hB0, 8'h00, 1, 1'b0, 4, 3, 1'b0);
        check_count("clear_final", bus_a.match_count, 8'd0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_exp(4, 8'd1);
        run_stream(8'hB0, 8'h00, 1, 1'b0, -1, 1, 1'b0);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'hB0;
        bus_a.overlap  = 1'b0;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_a.bit_out !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.match_count !== 8'd1) begin
            failures++;
            $display("FAIL pre_reset_state: bit=%b busy=%b cnt=%0d expected 1 1 1",
                     bus_a.bit_out, bus_a.busy, bus_a.match_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.bit_out !== 1'b0 ||
            bus_a.seq_seen !== 1'b0 || bus_a.match_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: rdy=%b busy=%b bit=%b seen=%b cnt=%0d expected 0 0 0 0 0",
                     bus_a.in_ready, bus_a.busy, bus_a.bit_out, bus_a.seq_seen, bus_a.match_count);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1 || bus_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release: rdy=%b busy=%b expected 1 0", bus_a.in_ready, bus_a.busy);
        end
        push_exp(4, 8'd1);
        run_stream(8'hB0, 8'h00, 1, 1'b0, -1, 3, 1'b0);
        check_count("after_reset_final", bus_a.match_count, 8'd1);
    endtask

    initial begin
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = 8'd0;
        bus_a.overlap  = 1'b0;
        bus_a.clear    = 1'b0;
        #1;
        test_reset();
        test_nonoverlap();
        test_mode();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
